sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO: the next generation of the team's 8-bit/16-entry synchronous FIFO. It adds configurable width and depth, and a first-word-fall-through (FWFT) mode. It also provides an occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags with an explicit clear. It sits between same-clock producer/consumer blocks as a drop-in buffer.

## Interface
Parameters:
- DATA_W, 8, data word width (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_TH, DEPTH-4, almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 4, almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)

Ports (AW = log2(DEPTH)):
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset: synchronous, active-low
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request (in FWFT mode: pop/acknowledge)
- rd_data  out  DATA_W  read data
- err_clr  in  1  clears the overflow and underflow sticky flags
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_TH
- almost_empty  out  1  count ≤ AEMPTY_TH
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- **Accept rules.**
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc). A write to a full FIFO succeeds only alongside an accepted read.
  - A read on an empty FIFO is rejected even if a write is accepted in the same cycle.
- **Storage.**
  - Write and read pointers are AW bits, incremented on accept, and wrap DEPTH-1 → 0 naturally.
  - Memory is written at wr_ptr on wr_acc.
- **Count update.** count += wr_acc − rd_acc every cycle: simultaneous accepted read and write leaves count unchanged.
- **Status flags.** full, empty, almost_full and almost_empty are decoded from the count register only, so they are effectively registered with no input-to-output combinational path.
- **Standard mode (FWFT=0).**
  - On rd_acc, rd_data is loaded from mem[rd_ptr].
  - Otherwise rd_data holds its previous value.
- **FWFT mode (FWFT=1).**
  - rd_data = mem[rd_ptr] whenever ~empty, so the head word is visible without a read.
  - rd_acc pops the head word.
  - rd_data is don't-care while empty.
- **Error flags.**
  - overflow sets on wr_en & ~wr_acc; underflow sets on rd_en & ~rd_acc.
  - Both clear on err_clr.
  - If set and clear occur in the same cycle, set wins.
  - Rejected operations change neither the pointers nor the memory.
- **Reset.**
  - Outputs: count=0, empty=1, full=0, almost_empty=1, almost_full=0 (assuming AFULL_TH ≥ 1), overflow=0, underflow=0, rd_data=0.
  - Pointers are set to 0.
  - Memory contents are not reset; a mid-operation reset discards all data.

## Timing
- Write at edge N: count and flags update after edge N, so empty falls in cycle N+1.
- Standard read, rd_en sampled at edge M: data is valid on rd_data in cycle M+1 (1-cycle latency).
- FWFT: the first word written at edge N appears on rd_data in cycle N+1, together with empty=0.
- Back-to-back reads and writes are supported every cycle, giving a throughput of 1 word/cycle each direction.
- Reset takes effect at the first rising edge with rst_n=0 and has priority over all other inputs.

## Structure
- Package sync_fifo_pkg holds:
  - the read-mode constants FIFO_STD=0 and FIFO_FWFT=1;
  - a log2 helper function for AW;
  - parameter legality checks (DEPTH a power of two, threshold ranges).
- Sub-module fifo_ram_2p(DATA_W, DEPTH): simple dual-port array with synchronous write and asynchronous read.
  - The top level owns the pointers, count, flags and the rd_data register (standard mode).

## Test plan
(DATA_W=8, DEPTH=16, AFULL_TH=12, AEMPTY_TH=4; both FWFT values unless noted.)
- **Fill.** Reset, then write 0x01..0x10 on consecutive cycles:
  - almost_empty drops when count=5 and almost_full rises when count=12;
  - full=1 and count=16 after the 16th write.
  - A 17th write is rejected: overflow=1, count stays 16.
- **Drain.** Continuing from the full FIFO, read 16 times:
  - data comes out in order 0x01..0x10;
  - FWFT=0: each word appears the cycle after its rd_en;
  - FWFT=1: 0x01 is already on rd_data before the first rd_en.
  - Ends with empty=1. A 17th read gives underflow=1.
- **Sticky clear.** Pulse err_clr with wr_en asserted on a full FIFO → overflow stays 1 (set wins). Then err_clr alone → 0.
- **Simultaneous at boundaries.**
  - Full FIFO, wr_en=rd_en=1 with 0xAA → both accepted, count stays 16, 0xAA becomes the tail entry.
  - Empty FIFO, wr_en=rd_en=1 → only the write is accepted, count=1, underflow=1.
- **Wrap-around.** 40 cycles of streaming with count held near 8 and random read/write mix → scoreboard matches every word and count never leaves 0..16.
- **Reset mid-operation.** With count=9, assert rst_n=0 for one cycle:
  - next cycle count=0, empty=1 and all flags are at reset values;
  - a subsequent write of 0x5A is read back as 0x5A.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants, width helper and parameter legality checks for sync_fifo_param.
package sync_fifo_pkg;

    localparam int unsigned FIFO_STD  = 0;
    localparam int unsigned FIFO_FWFT = 1;

    // Number of address bits needed to index 'value' entries
    function automatic int unsigned log2_ceil(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    // Whole-configuration sanity check used at elaboration
    function automatic bit params_legal(
        input int unsigned data_w,
        input int unsigned depth,
        input int unsigned fwft,
        input int unsigned afull_th,
        input int unsigned aempty_th
    );
        return (data_w >= 1) && (depth >= 4) && is_pow2(depth) &&
               (fwft <= FIFO_FWFT) &&
               (afull_th >= 1) && (afull_th <= depth) &&
               (aempty_th <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
module fifo_ram_2p
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [log2_ceil(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [log2_ceil(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]             rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read,
// occupancy count, almost thresholds and sticky overflow/underflow flags.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FWFT      = FIFO_STD,
    parameter int unsigned AFULL_TH  = DEPTH - 4,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    input  logic                        err_clr,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [log2_ceil(DEPTH):0]   count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned AW = log2_ceil(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (!params_legal(DATA_W, DEPTH, FWFT, AFULL_TH, AEMPTY_TH)) begin : g_param_check
        $error("sync_fifo_param: illegal parameter set");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              rd_acc;
    logic              wr_acc;
    logic [CW-1:0]     count_nxt;
    logic [DATA_W-1:0] ram_rd_data;

    // Accept decisions and next occupancy; a full FIFO takes a write only alongside a pop
    always_comb begin
        rd_acc    = rd_en & ~empty;
        wr_acc    = wr_en & (~full | rd_acc);
        count_nxt = count + CW'(wr_acc) - CW'(rd_acc);
    end

    // Pointers, occupancy, status flags (decoded from next count) and sticky errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AFULL_TH));
            almost_empty <= (count_nxt <= CW'(AEMPTY_TH));
            overflow     <= (wr_en & ~wr_acc) | (overflow & ~err_clr);
            underflow    <= (rd_en & ~rd_acc) | (underflow & ~err_clr);
        end
    end

    fifo_ram_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head word shown straight from the array; parked at zero while empty
        assign rd_data = empty ? '0 : ram_rd_data;
    end else begin : g_std
        // Registered read: load the head word on an accepted read, else hold
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_data <= '0;
            end else if (rd_acc) begin
                rd_data <= ram_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: standard and FWFT instances share one stimulus stream;
// a queue model predicts read data and status, monitors pop and compare on each read.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] wr_data = 8'h00;

    logic [7:0] rd_data_s, rd_data_f;
    logic       full_s, empty_s, afull_s, aempty_s, ovf_s, udf_s;
    logic       full_f, empty_f, afull_f, aempty_f, ovf_f, udf_f;
    logic [4:0] count_s, count_f;

    int         total = 0;
    int         bad = 0;
    int         mcnt = 0;
    bit         movf = 1'b0;
    bit         mudf = 1'b0;
    bit         pend_s = 1'b0;
    logic [7:0] mq[$];
    logic [7:0] exp_s[$];
    logic [7:0] exp_f[$];
    logic [7:0] e_s, e_f;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(4)
    ) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data_s), .err_clr(err_clr),
        .full(full_s), .empty(empty_s), .almost_full(afull_s),
        .almost_empty(aempty_s), .count(count_s),
        .overflow(ovf_s), .underflow(udf_s)
    );

    sync_fifo_param #(
        .DATA_W(8), .DEPTH(16), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(4)
    ) u_fw (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data_f), .err_clr(err_clr),
        .full(full_f), .empty(empty_f), .almost_full(afull_f),
        .almost_empty(aempty_f), .count(count_f),
        .overflow(ovf_f), .underflow(udf_f)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic sb_underrun(input string name);
        total++;
        bad++;
        $display("FAIL %s: read seen with no expected word queued at %0t", name, $time);
    endtask

    // Standard monitor: a read accepted at an edge shows its word in the following cycle
    always @(negedge clk) begin
        if (pend_s) begin
            if (exp_s.size() == 0) begin
                sb_underrun("std_sb");
            end else begin
                e_s = exp_s.pop_front();
                chk("std_rd_data", 32'(rd_data_s), 32'(e_s));
            end
        end
        pend_s = rst_n && rd_en && !empty_s;
    end

    // FWFT monitor: the word being popped is on rd_data before the accepting edge
    always @(negedge clk) begin
        if (rst_n && rd_en && !empty_f) begin
            if (exp_f.size() == 0) begin
                sb_underrun("fwft_sb");
            end else begin
                e_f = exp_f.pop_front();
                chk("fwft_rd_data", 32'(rd_data_f), 32'(e_f));
            end
        end
    end

    task automatic check_status();
        chk("count_s",  32'(count_s),  32'(mcnt));
        chk("count_f",  32'(count_f),  32'(mcnt));
        chk("full_s",   32'(full_s),   32'(mcnt == 16));
        chk("full_f",   32'(full_f),   32'(mcnt == 16));
        chk("empty_s",  32'(empty_s),  32'(mcnt == 0));
        chk("empty_f",  32'(empty_f),  32'(mcnt == 0));
        chk("afull_s",  32'(afull_s),  32'(mcnt >= 12));
        chk("afull_f",  32'(afull_f),  32'(mcnt >= 12));
        chk("aempty_s", 32'(aempty_s), 32'(mcnt <= 4));
        chk("aempty_f", 32'(aempty_f), 32'(mcnt <= 4));
        chk("ovf_s",    32'(ovf_s),    32'(movf));
        chk("ovf_f",    32'(ovf_f),    32'(movf));
        chk("udf_s",    32'(udf_s),    32'(mudf));
        chk("udf_f",    32'(udf_f),    32'(mudf));
    endtask

    // One clock of stimulus; model predicts accepts, queues expected read words, then checks status
    task automatic step(input bit we, input logic [7:0] wd, input bit re, input bit clr, input bit rst);
        bit         m_rd;
        bit         m_wr;
        logic [7:0] w;
        rst_n   = !rst;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        err_clr = clr;
        m_rd = !rst && re && (mcnt > 0);
        m_wr = !rst && we && ((mcnt < 16) || m_rd);
        if (m_rd) begin
            w = mq.pop_front();
            exp_s.push_back(w);
            exp_f.push_back(w);
        end
        if (m_wr) begin
            mq.push_back(wd);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            mcnt = 0;
            movf = 1'b0;
            mudf = 1'b0;
            mq.delete();
            exp_s.delete();
            exp_f.delete();
        end else begin
            mcnt = mcnt + int'(m_wr) - int'(m_rd);
            movf = (we && !m_wr) || (movf && !clr);
            mudf = (re && !m_rd) || (mudf && !clr);
        end
        check_status();
    endtask

    initial begin
        // Reset state
        step(0, 8'h00, 0, 0, 1);
        chk("reset_rd_data_s", 32'(rd_data_s), 32'h0);

        // Fill 0x01..0x10 with hand-picked threshold crossings
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i + 1), 0, 0, 0);
            if (i == 3)  chk("aempty_at4",  32'(aempty_s), 32'h1);
            if (i == 4)  chk("aempty_at5",  32'(aempty_s), 32'h0);
            if (i == 10) chk("afull_at11",  32'(afull_f),  32'h0);
            if (i == 11) chk("afull_at12",  32'(afull_f),  32'h1);
            if (i == 15) chk("full_at16",   32'(full_s),   32'h1);
        end
        step(1, 8'h11, 0, 0, 0);
        chk("overflow_17th", 32'(ovf_s), 32'h1);
        chk("count_after_17th", 32'(count_f), 32'd16);

        // Sticky clear: set wins over clear, then clear alone
        step(1, 8'h12, 0, 1, 0);
        chk("ovf_set_wins", 32'(ovf_f), 32'h1);
        step(0, 8'h00, 0, 1, 0);
        chk("ovf_cleared", 32'(ovf_s), 32'h0);

        // Drain; FWFT head already visible
        chk("fwft_head_preview", 32'(rd_data_f), 32'h01);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, 0);
        end
        step(0, 8'h00, 1, 0, 0);
        chk("underflow_17th", 32'(udf_s), 32'h1);
        chk("std_last_word", 32'(rd_data_s), 32'h10);
        step(0, 8'h00, 0, 1, 0);

        // Empty FIFO: simultaneous read and write, only the write lands
        step(1, 8'h3C, 1, 0, 0);
        chk("empty_rw_count", 32'(count_s), 32'd1);
        chk("empty_rw_udf", 32'(udf_f), 32'h1);
        step(0, 8'h00, 0, 1, 0);

        // Full FIFO: simultaneous read and write, 0xAA becomes the tail
        for (int i = 0; i < 15; i++) begin
            step(1, 8'(8'h41 + i), 0, 0, 0);
        end
        step(1, 8'hAA, 1, 0, 0);
        chk("full_rw_count", 32'(count_f), 32'd16);
        chk("full_rw_no_ovf", 32'(ovf_s), 32'h0);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, 0);
        end
        step(0, 8'h00, 0, 0, 0);
        chk("tail_is_aa", 32'(rd_data_s), 32'hAA);

        // Streaming across the pointer wrap with occupancy held near 8
        for (int i = 0; i < 8; i++) begin
            step(1, 8'(8'h80 + i), 0, 0, 0);
        end
        for (int i = 0; i < 40; i++) begin
            step((i % 4) != 3, 8'(8'hC0 + i), (i % 4) != 1, 0, 0);
        end

        // Mid-operation reset at count 9
        for (int k = 0; k < 16 && mcnt < 9; k++) begin
            step(1, 8'(8'hE0 + k), 0, 0, 0);
        end
        chk("count_before_reset", 32'(count_s), 32'd9);
        step(0, 8'h00, 0, 0, 1);
        chk("midreset_rd_data_s", 32'(rd_data_s), 32'h0);
        step(1, 8'h5A, 0, 0, 0);
        chk("fwft_5a_visible", 32'(rd_data_f), 32'h5A);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("std_5a_read", 32'(rd_data_s), 32'h5A);
        step(0, 8'h00, 0, 0, 0);

        chk("sb_drained_s", 32'(exp_s.size()), 32'd0);
        chk("sb_drained_f", 32'(exp_f.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
